controller_sequencer_v2: RTL and testbench

CONTROLLER_SEQUENCER_V2 -- requirements
Module: controller_sequencer_v2

---
 rtl/sap_pkg.sv | 53 +++++
 rtl/ring_counter.sv | 37 +++
 rtl/controller_sequencer_v2.sv | 161 ++++++++++++++++
 tb/tb_controller_sequencer_v2.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-style controller/sequencer: opcodes,
// T-state bit indices and control-word bit positions.
package sap_pkg;

  // Opcodes carried in the IR upper nibble
  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_STA = 4'd3;
  localparam logic [3:0] OP_LDI = 4'd4;
  localparam logic [3:0] OP_JMP = 4'd5;
  localparam logic [3:0] OP_JZ  = 4'd6;
  localparam logic [3:0] OP_JC  = 4'd7;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  // One-hot T-state bit indices (T1 is bit 0)
  localparam int NUM_T = 6;
  localparam int T1 = 0;
  localparam int T2 = 1;
  localparam int T3 = 2;
  localparam int T4 = 3;
  localparam int T5 = 4;
  localparam int T6 = 5;

  // Control-word bit positions; every bit is "asserted" = 1 internally,
  // active-low ports are inverted only at the module boundary.
  localparam int CW_CP  = 0;
  localparam int CW_EP  = 1;
  localparam int CW_EA  = 2;
  localparam int CW_SU  = 3;
  localparam int CW_EU  = 4;
  localparam int CW_WE  = 5;
  localparam int CW_LM  = 6;
  localparam int CW_CE  = 7;
  localparam int CW_LI  = 8;
  localparam int CW_EI  = 9;
  localparam int CW_LA  = 10;
  localparam int CW_LB  = 11;
  localparam int CW_LO  = 12;
  localparam int CW_LP  = 13;
  localparam int CW_HLT = 14;
  localparam int CW_W   = 15;

  typedef logic [CW_W-1:0] ctrl_word_t;

  // Sequencer run/halt mode
  typedef enum logic {
    SEQ_RUN  = 1'b0,
    SEQ_HALT = 1'b1
  } seq_mode_e;

endpackage

// File: rtl/ring_counter.sv
// Six-stage one-hot T-state ring counter with advance enable and a
// synchronous restart back to T1.
module ring_counter
  import sap_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             restart,
  output logic [NUM_T-1:0] state
);

  logic [NUM_T-1:0] ring_q;
  logic [NUM_T-1:0] ring_d;

  // Next ring value: restart wins, otherwise rotate toward T6 and wrap to T1
  always_comb begin
    ring_d = ring_q;
    if (restart) begin
      ring_d = NUM_T'(1);
    end else if (en) begin
      ring_d = {ring_q[NUM_T-2:0], ring_q[NUM_T-1]};
    end
  end

  // Ring register, cleared to T1
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ring_q <= NUM_T'(1);
    end else begin
      ring_q <= ring_d;
    end
  end

  assign state = ring_q;

endmodule

// File: rtl/controller_sequencer_v2.sv
// Microcoded controller/sequencer: T-state ring, sticky halt, and
// combinational control-word decode from state, opcode, flags and advance.
module controller_sequencer_v2
  import sap_pkg::*;
#(
  parameter bit EARLY_END = 1'b1,
  parameter bit STEP_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] op_code,
  input  logic       zero_flag,
  input  logic       carry_flag,
  input  logic       run_mode,
  input  logic       step,
  output logic       cp,
  output logic       ep,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       we,
  output logic       lm_n,
  output logic       ce_n,
  output logic       li_n,
  output logic       ei_n,
  output logic       la_n,
  output logic       lb_n,
  output logic       lo_n,
  output logic       lp_n,
  output logic       hlt_n,
  output logic [5:0] state,
  output logic       instr_done
);

  seq_mode_e  mode_q, mode_d;
  ctrl_word_t cw, cw_out;
  logic       adv, last_state, hlt_stop, halted;

  assign halted = (mode_q == SEQ_HALT);
  assign adv    = (run_mode | ~STEP_EN | step) & ~halted;

  ring_counter u_ring (
    .clk     (clk),
    .clr     (clr),
    .en      (adv & ~hlt_stop),
    .restart (adv & last_state & EARLY_END),
    .state   (state)
  );

  // Halt mode register, cleared back to run
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mode_q <= SEQ_RUN;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Microcode decode; strobes are qualified by adv, enables follow state
  always_comb begin
    mode_d     = mode_q;
    cw         = '0;
    last_state = 1'b0;
    hlt_stop   = 1'b0;
    if (halted) begin
      cw[CW_HLT] = 1'b1;
    end else if (state[T1]) begin
      cw[CW_EP] = 1'b1;
      cw[CW_LM] = adv;
    end else if (state[T2]) begin
      cw[CW_CP] = adv;
    end else if (state[T3]) begin
      cw[CW_CE] = 1'b1;
      cw[CW_LI] = adv;
    end else if (state[T4]) begin
      case (op_code)
        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
          cw[CW_EI] = 1'b1;
          cw[CW_LM] = adv;
        end
        OP_LDI: begin
          cw[CW_EI]  = 1'b1;
          cw[CW_LA]  = adv;
          last_state = 1'b1;
        end
        OP_JMP: begin
          cw[CW_EI]  = 1'b1;
          cw[CW_LP]  = adv;
          last_state = 1'b1;
        end
        OP_JZ: begin
          cw[CW_EI]  = 1'b1;
          cw[CW_LP]  = adv & zero_flag;
          last_state = 1'b1;
        end
        OP_JC: begin
          cw[CW_EI]  = 1'b1;
          cw[CW_LP]  = adv & carry_flag;
          last_state = 1'b1;
        end
        OP_OUT: begin
          cw[CW_EA]  = 1'b1;
          cw[CW_LO]  = adv;
          last_state = 1'b1;
        end
        OP_HLT: begin
          cw[CW_HLT] = 1'b1;
          hlt_stop   = 1'b1;
          if (adv) mode_d = SEQ_HALT;
        end
        default: last_state = 1'b1;
      endcase
    end else if (state[T5]) begin
      case (op_code)
        OP_LDA: begin
          cw[CW_CE]  = 1'b1;
          cw[CW_LA]  = adv;
          last_state = 1'b1;
        end
        OP_ADD, OP_SUB: begin
          cw[CW_CE] = 1'b1;
          cw[CW_LB] = adv;
        end
        OP_STA: begin
          cw[CW_EA]  = 1'b1;
          cw[CW_WE]  = adv;
          last_state = 1'b1;
        end
        default: ;
      endcase
    end else if (state[T6]) begin
      if (op_code == OP_ADD || op_code == OP_SUB) begin
        cw[CW_EU]  = 1'b1;
        cw[CW_SU]  = (op_code == OP_SUB);
        cw[CW_LA]  = adv;
        last_state = 1'b1;
      end
    end
  end

  // Reset must silence every output immediately, not only after the edge
  assign cw_out     = clr ? '0 : cw;
  assign instr_done = ~clr & adv & last_state;

  assign cp    = cw_out[CW_CP];
  assign ep    = cw_out[CW_EP];
  assign ea    = cw_out[CW_EA];
  assign su    = cw_out[CW_SU];
  assign eu    = cw_out[CW_EU];
  assign we    = cw_out[CW_WE];
  assign lm_n  = ~cw_out[CW_LM];
  assign ce_n  = ~cw_out[CW_CE];
  assign li_n  = ~cw_out[CW_LI];
  assign ei_n  = ~cw_out[CW_EI];
  assign la_n  = ~cw_out[CW_LA];
  assign lb_n  = ~cw_out[CW_LB];
  assign lo_n  = ~cw_out[CW_LO];
  assign lp_n  = ~cw_out[CW_LP];
  assign hlt_n = ~cw_out[CW_HLT];

endmodule

// File: tb/tb_controller_sequencer_v2.sv
// Testbench for controller_sequencer_v2: directed table, hand sequences
// and randomized stimulus against an instruction-level reference model.
module tb_controller_sequencer_v2;

  // Observation vector layout (asserted = 1 for every signal)
  localparam logic [15:0] V_CP = 16'h8000, V_EP = 16'h4000, V_EA = 16'h2000, V_SU = 16'h1000;
  localparam logic [15:0] V_EU = 16'h0800, V_WE = 16'h0400, V_LM = 16'h0200, V_CE = 16'h0100;
  localparam logic [15:0] V_LI = 16'h0080, V_EI = 16'h0040, V_LA = 16'h0020, V_LB = 16'h0010;
  localparam logic [15:0] V_LO = 16'h0008, V_LP = 16'h0004, V_HLT = 16'h0002, V_DONE = 16'h0001;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic [3:0] op = 4'd0;
  logic zf = 1'b0, cf = 1'b0, run = 1'b1, stp = 1'b0;

  logic cp1, ep1, ea1, su1, eu1, we1, lm_n1, ce_n1, li_n1, ei_n1, la_n1, lb_n1, lo_n1, lp_n1, hlt_n1, done1;
  logic cp0, ep0, ea0, su0, eu0, we0, lm_n0, ce_n0, li_n0, ei_n0, la_n0, lb_n0, lo_n0, lp_n0, hlt_n0, done0;
  logic [5:0] st1, st0;
  logic [15:0] vec1, vec0;

  int total = 0;
  int bad = 0;
  int mt[2];
  bit mh[2];

  always #5 clk = ~clk;

  controller_sequencer_v2 #(.EARLY_END(1'b1), .STEP_EN(1'b1)) dut (
    .clk(clk), .clr(clr), .op_code(op), .zero_flag(zf), .carry_flag(cf),
    .run_mode(run), .step(stp),
    .cp(cp1), .ep(ep1), .ea(ea1), .su(su1), .eu(eu1), .we(we1),
    .lm_n(lm_n1), .ce_n(ce_n1), .li_n(li_n1), .ei_n(ei_n1), .la_n(la_n1),
    .lb_n(lb_n1), .lo_n(lo_n1), .lp_n(lp_n1), .hlt_n(hlt_n1),
    .state(st1), .instr_done(done1)
  );

  controller_sequencer_v2 #(.EARLY_END(1'b0), .STEP_EN(1'b1)) dut_full (
    .clk(clk), .clr(clr), .op_code(op), .zero_flag(zf), .carry_flag(cf),
    .run_mode(run), .step(stp),
    .cp(cp0), .ep(ep0), .ea(ea0), .su(su0), .eu(eu0), .we(we0),
    .lm_n(lm_n0), .ce_n(ce_n0), .li_n(li_n0), .ei_n(ei_n0), .la_n(la_n0),
    .lb_n(lb_n0), .lo_n(lo_n0), .lp_n(lp_n0), .hlt_n(hlt_n0),
    .state(st0), .instr_done(done0)
  );

  assign vec1 = {cp1, ep1, ea1, su1, eu1, we1, ~lm_n1, ~ce_n1, ~li_n1, ~ei_n1,
                 ~la_n1, ~lb_n1, ~lo_n1, ~lp_n1, ~hlt_n1, done1};
  assign vec0 = {cp0, ep0, ea0, su0, eu0, we0, ~lm_n0, ~ce_n0, ~li_n0, ~ei_n0,
                 ~la_n0, ~lb_n0, ~lo_n0, ~lp_n0, ~hlt_n0, done0};

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Instruction length in T-states, derived from the instruction set table
  function automatic int len_of(input logic [3:0] o);
    case (o)
      4'd0, 4'd3: return 5;
      4'd1, 4'd2: return 6;
      default:    return 4;
    endcase
  endfunction

  // Expected outputs for T-state t: level enables plus strobes that only fire on adv
  function automatic logic [15:0] model_vec(input int t, input bit halted, input bit c_i,
                                            input logic [3:0] o, input bit z, input bit c,
                                            input bit adv);
    logic [15:0] en, sb;
    en = '0;
    sb = '0;
    if (c_i) return '0;
    if (halted) return V_HLT;
    if (t == 1) begin en = V_EP; sb = V_LM; end
    else if (t == 2) sb = V_CP;
    else if (t == 3) begin en = V_CE; sb = V_LI; end
    else if (t <= len_of(o)) begin
      case (o)
        4'd0:       if (t == 4) begin en = V_EI; sb = V_LM; end else begin en = V_CE; sb = V_LA; end
        4'd1, 4'd2: if (t == 4) begin en = V_EI; sb = V_LM; end
                    else if (t == 5) begin en = V_CE; sb = V_LB; end
                    else begin en = V_EU | ((o == 4'd2) ? V_SU : 16'h0); sb = V_LA; end
        4'd3:       if (t == 4) begin en = V_EI; sb = V_LM; end else begin en = V_EA; sb = V_WE; end
        4'd4:       begin en = V_EI; sb = V_LA; end
        4'd5:       begin en = V_EI; sb = V_LP; end
        4'd6:       begin en = V_EI; sb = z ? V_LP : 16'h0; end
        4'd7:       begin en = V_EI; sb = c ? V_LP : 16'h0; end
        4'd14:      begin en = V_EA; sb = V_LO; end
        4'd15:      en = V_HLT;
        default:    ;
      endcase
      if (t == len_of(o) && o != 4'd15) sb |= V_DONE;
    end
    return en | (adv ? sb : 16'h0);
  endfunction

  // One cycle: compare both instances to the model, then advance the model on the edge
  task automatic step_cycle(input string tag);
    bit adv [2];
    logic [15:0] ev;
    logic [5:0] es;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      adv[i] = (run | stp) & ~mh[i];
      ev = model_vec(mt[i], mh[i], clr, op, zf, cf, adv[i]);
      es = clr ? 6'b000001 : 6'(1 << (mt[i] - 1));
      chk($sformatf("%s_state_e%0d", tag, i), {10'd0, (i == 1) ? st1 : st0}, {10'd0, es});
      chk($sformatf("%s_ctrl_e%0d", tag, i), (i == 1) ? vec1 : vec0, ev);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        mt[i] = 1;
        mh[i] = 1'b0;
      end else if (adv[i]) begin
        if (mt[i] == 4 && op == 4'd15) mh[i] = 1'b1;
        else if ((i == 1 && mt[i] == len_of(op)) || mt[i] == 6) mt[i] = 1;
        else mt[i] = mt[i] + 1;
      end
    end
    #1;
  endtask

  // Hold clr for one cycle (checked while asserted) and release
  task automatic do_reset(input string tag);
    clr = 1'b1;
    step_cycle(tag);
    clr = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    bit          z;
    bit          c;
    logic [5:0]  st;
    logic [15:0] vec;
  } row_t;
  row_t rows[$];

  task automatic add_row(input logic [3:0] o, input bit z, input bit c,
                         input logic [5:0] s, input logic [15:0] v);
    row_t r;
    r.op = o; r.z = z; r.c = c; r.st = s; r.vec = v;
    rows.push_back(r);
  endtask

  task automatic add_fetch(input logic [3:0] o, input bit z, input bit c);
    add_row(o, z, c, 6'b000001, V_EP | V_LM);
    add_row(o, z, c, 6'b000010, V_CP);
    add_row(o, z, c, 6'b000100, V_CE | V_LI);
  endtask

  initial begin
    logic [5:0]  full_st [7];
    logic [15:0] full_vec[7];
    logic [5:0]  exp_st;
    int idx;

    // Directed table for the EARLY_END=1 instance, free-running
    add_fetch(4'd1, 0, 0);
    add_row(4'd1, 0, 0, 6'b001000, V_EI | V_LM);
    add_row(4'd1, 0, 0, 6'b010000, V_CE | V_LB);
    add_row(4'd1, 0, 0, 6'b100000, V_EU | V_LA | V_DONE);
    add_fetch(4'd2, 0, 0);
    add_row(4'd2, 0, 0, 6'b001000, V_EI | V_LM);
    add_row(4'd2, 0, 0, 6'b010000, V_CE | V_LB);
    add_row(4'd2, 0, 0, 6'b100000, V_EU | V_SU | V_LA | V_DONE);
    add_fetch(4'd4, 0, 0);
    add_row(4'd4, 0, 0, 6'b001000, V_EI | V_LA | V_DONE);
    add_fetch(4'd6, 1, 0);
    add_row(4'd6, 1, 0, 6'b001000, V_EI | V_LP | V_DONE);
    add_fetch(4'd6, 0, 1);
    add_row(4'd6, 0, 1, 6'b001000, V_EI | V_DONE);
    add_fetch(4'd7, 0, 1);
    add_row(4'd7, 0, 1, 6'b001000, V_EI | V_LP | V_DONE);
    add_row(4'd0, 0, 0, 6'b000001, V_EP | V_LM);

    run = 1'b1; stp = 1'b0;
    mt[0] = 1; mt[1] = 1; mh[0] = 1'b0; mh[1] = 1'b0;
    do_reset("reset");
    for (int r = 0; r < rows.size(); r++) begin
      op = rows[r].op; zf = rows[r].z; cf = rows[r].c;
      @(negedge clk);
      chk($sformatf("row%0d_state", r), {10'd0, st1}, {10'd0, rows[r].st});
      chk($sformatf("row%0d_ctrl", r), vec1, rows[r].vec);
      $display("row %0d op=%0d state=%b ctrl=%h", r, op, st1, vec1);
      @(posedge clk); #1;
    end

    // LDI on the full-length instance: idle T5/T6 then back to T1
    op = 4'd4; zf = 0; cf = 0;
    do_reset("reset_full");
    full_st  = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b000001};
    full_vec = '{V_EP | V_LM, V_CP, V_CE | V_LI, V_EI | V_LA | V_DONE, 16'h0, 16'h0, V_EP | V_LM};
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("full_ldi%0d_state", k), {10'd0, st0}, {10'd0, full_st[k]});
      chk($sformatf("full_ldi%0d_ctrl", k), vec0, full_vec[k]);
      $display("full ldi cycle %0d state=%b ctrl=%h", k, st0, vec0);
      @(posedge clk); #1;
    end

    // Single-step: step every third cycle through an LDA
    op = 4'd0;
    do_reset("reset_step");
    run = 1'b0;
    for (int k = 0; k < 18; k++) begin
      stp = (k % 3 == 2);
      idx = k / 3;
      exp_st = (idx < 5) ? 6'(1 << idx) : 6'b000001;
      @(negedge clk);
      chk($sformatf("step%0d_state", k), {10'd0, st1}, {10'd0, exp_st});
      chk($sformatf("step%0d_cp", k), {15'd0, cp1}, {15'd0, (k == 5)});
      if (k < 3) chk($sformatf("step%0d_ep", k), {15'd0, ep1}, 16'd1);
      $display("step cycle %0d step=%0d state=%b cp=%0d ep=%0d", k, stp, st1, cp1, ep1);
      @(posedge clk); #1;
    end
    stp = 1'b0;
    run = 1'b1;

    // HLT freezes at T4 until clr
    op = 4'd15;
    do_reset("reset_hlt");
    for (int k = 0; k < 3; k++) step_cycle("hlt_fetch");
    for (int k = 0; k < 20; k++) begin
      step_cycle("hlt_hold");
      chk($sformatf("hlt%0d_state", k), {10'd0, st1}, 16'h0008);
      chk($sformatf("hlt%0d_hlt_n", k), {15'd0, hlt_n1}, 16'd0);
    end
    $display("halt held state=%b hlt_n=%0d", st1, hlt_n1);
    clr = 1'b1;
    #1;
    chk("hlt_clr_state", {10'd0, st1}, 16'h0001);
    chk("hlt_clr_hlt_n", {15'd0, hlt_n1}, 16'd1);
    step_cycle("hlt_clr");
    clr = 1'b0;

    // Randomized run against the model, including mid-instruction clr
    for (int k = 0; k < 800; k++) begin
      op  = 4'($urandom_range(0, 15));
      if (op == 4'd15 && $urandom_range(0, 1) == 0) op = 4'd1;
      zf  = 1'($urandom);
      cf  = 1'($urandom);
      run = ($urandom_range(0, 3) != 0);
      stp = 1'($urandom);
      if ($urandom_range(0, 39) == 0) do_reset("rand_clr");
      else step_cycle("rand");
    end
    $display("random phase done state=%b", st1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
